// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad calculator controller with shift-add multiply, double-dabble conversion
// and a valid/ready character output stream.
module calc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_out,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, OPA, OPB, MUL, CONV, OUT, ERR} state_t;
    localparam logic [1:0] OP_MUL = 2'd0, OP_ADD = 2'd2, OP_SUB = 2'd3;

    state_t state, state_nxt;
    logic [7:0] a, b, cur;
    logic [1:0] op, dcnt;
    logic [15:0] result;
    logic neg, sign, e_sent;
    logic [19:0] bcd, bcd_adj, bcd_nxt;
    logic [3:0] cnt, dsel;
    logic [2:0] idx, lead;
    logic [11:0] val;
    logic is_digit, is_op, is_eq, is_clr, xfer, too_big;

    always_comb begin
        is_digit = key_valid && key_code < 4'd10;
        is_op = key_valid && key_code >= 4'd10 && key_code <= 4'd12;
        is_eq = key_valid && key_code == 4'd13;
        is_clr = key_valid && key_code == 4'd14;
        cur = state == OPB ? b : a;
        val = 12'(cur) * 12'd10 + 12'(key_code);
        too_big = dcnt == 2'd3 || val > 12'd255;
        for (int i = 0; i < 5; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        bcd_nxt = {bcd_adj[18:0], result[15]};
        lead = bcd_nxt[19:16] != 4'd0 ? 3'd0 : bcd_nxt[15:12] != 4'd0 ? 3'd1 :
               bcd_nxt[11:8] != 4'd0 ? 3'd2 : bcd_nxt[7:4] != 4'd0 ? 3'd3 : 3'd4;
        dsel = 4'(bcd >> {3'd4 - idx, 2'b00});
        char_valid = state == OUT || (state == ERR && !e_sent);
        char_out = !char_valid ? 8'h43 : state == ERR ? 8'h45 : sign ? 8'h2d : 8'h30 + {4'h0, dsel};
        xfer = char_valid && char_ready;
        busy = state == MUL || state == CONV || state == OUT;
        err = state == ERR;
    end

    always_comb begin
        state_nxt = state;
        if (is_clr)
            state_nxt = IDLE;
        else
            case (state)
                IDLE: state_nxt = is_digit ? OPA : IDLE;
                OPA: state_nxt = is_digit && too_big ? ERR : is_op ? OPB : is_eq ? CONV : OPA;
                OPB: state_nxt = is_digit && too_big ? ERR :
                                 !is_eq ? OPB : dcnt == 2'd0 ? ERR : op == OP_MUL ? MUL : CONV;
                MUL: state_nxt = cnt == 4'd7 ? CONV : MUL;
                CONV: state_nxt = cnt == 4'd15 ? OUT : CONV;
                OUT: state_nxt = xfer && !sign && idx == 3'd4 ? IDLE : OUT;
                default: state_nxt = ERR;
            endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || is_clr) begin
            a <= '0;
            b <= '0;
            op <= '0;
            dcnt <= '0;
            result <= '0;
            neg <= 1'b0;
            sign <= 1'b0;
            e_sent <= 1'b0;
            bcd <= '0;
            cnt <= '0;
            idx <= '0;
        end else begin
            if (state != ERR) e_sent <= 1'b0;
            case (state)
                IDLE: if (is_digit) begin
                    a <= 8'(key_code);
                    dcnt <= 2'd1;
                end
                OPA, OPB: begin
                    if (is_digit) begin
                        if (state == OPA) a <= val[7:0];
                        else b <= val[7:0];
                        dcnt <= dcnt + 2'd1;
                    end
                    // An operator in OPB only replaces the pending one before any B digit
                    if (is_op && (state == OPA || dcnt == 2'd0)) begin
                        op <= key_code[1:0];
                        b <= '0;
                        dcnt <= '0;
                    end
                    if (is_eq) begin
                        cnt <= '0;
                        bcd <= '0;
                        neg <= state == OPB && op == OP_SUB && a < b;
                        result <= state == OPA ? 16'(a) : op == OP_ADD ? 16'(a) + 16'(b) :
                                  op == OP_MUL ? 16'd0 : a < b ? 16'(b - a) : 16'(a - b);
                    end
                end
                MUL: begin
                    // MSB-first shift-add: one multiplier bit per cycle
                    result <= {result[14:0], 1'b0} + (b[7] ? 16'(a) : 16'd0);
                    b <= {b[6:0], 1'b0};
                    cnt <= cnt == 4'd7 ? 4'd0 : cnt + 4'd1;
                end
                CONV: begin
                    bcd <= bcd_nxt;
                    result <= {result[14:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        idx <= lead;
                        sign <= neg;
                    end
                end
                OUT: if (xfer) begin
                    if (sign) sign <= 1'b0;
                    else idx <= idx + 3'd1;
                end
                default: if (xfer) e_sent <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed checks of calc_ctrl arithmetic, output stream, error and abort paths.
module tb_calc_ctrl;
    logic clk = 1'b0, reset = 1'b1, key_valid = 1'b0, char_ready = 1'b1;
    logic [3:0] key_code = 4'd15;
    logic char_valid, busy, err;
    logic [7:0] char_out;
    int compared = 0, mismatched = 0;

    calc_ctrl dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .char_ready(char_ready), .char_valid(char_valid), .char_out(char_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code = 4'd15;
    endtask

    task automatic get_char(input logic [7:0] exp, input string tag);
        int n = 0;
        while (char_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, char_out, exp);
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        @(negedge clk);
        chk("rst_valid", char_valid, 0);
        chk("rst_out", char_out, 8'h43);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        key(1); key(2); key(10); key(7); key(13);
        chk("add_busy", busy, 1);
        repeat (15) @(negedge clk);
        chk("add_conv16", char_valid, 0);
        @(negedge clk);
        chk("add_c0", char_out, 8'h31);
        @(negedge clk);
        chk("add_c1", char_out, 8'h39);
        @(negedge clk);
        chk("add_done_valid", char_valid, 0);
        chk("add_done_out", char_out, 8'h43);
        chk("add_done_busy", busy, 0);

        key(3); key(11); key(5); key(13);
        get_char(8'h2d, "sub_minus");
        chk("sub_c1", char_out, 8'h32);
        @(negedge clk);
        chk("sub_done", char_valid, 0);

        key(2); key(5); key(5); key(12); key(2); key(5); key(5); key(13);
        repeat (23) begin
            chk("mul_busy", busy, 1);
            @(negedge clk);
        end
        chk("mul_timing", char_valid, 0);
        @(negedge clk);
        chk("mul_c0", char_out, 8'h36);
        @(negedge clk);
        chk("mul_c1", char_out, 8'h35);
        @(negedge clk);
        chk("mul_c2", char_out, 8'h30);
        @(negedge clk);
        chk("mul_c3", char_out, 8'h32);
        @(negedge clk);
        chk("mul_c4", char_out, 8'h35);
        @(negedge clk);
        chk("mul_done", char_valid, 0);

        key(2); key(5); key(6);
        chk("err_flag", err, 1);
        chk("err_char", char_out, 8'h45);
        @(negedge clk);
        chk("err_once", char_valid, 0);
        key(7);
        chk("err_ignore_digit", err, 1);
        chk("err_ignore_valid", char_valid, 0);
        key(14);
        chk("err_clear", err, 0);
        chk("err_clear_busy", busy, 0);

        char_ready = 1'b0;
        key(1); key(9); key(13);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", char_valid, 1);
            chk("stall_out", char_out, 8'h31);
            @(negedge clk);
        end
        char_ready = 1'b1;
        @(negedge clk);
        chk("stall_c1", char_out, 8'h39);
        @(negedge clk);
        chk("stall_done", char_valid, 0);

        key(1); key(2); key(10); key(7); key(13);
        get_char(8'h31, "clr_c0");
        chk("clr_c1_pending", char_out, 8'h39);
        char_ready = 1'b0;
        key(14);
        chk("clr_mid_out", char_valid, 0);
        chk("clr_mid_busy", busy, 0);
        char_ready = 1'b1;

        key(4); key(10); key(13);
        chk("eq_no_b_err", err, 1);
        get_char(8'h45, "eq_no_b_char");
        key(14);

        key(8); key(10); key(12); key(3); key(13);
        get_char(8'h32, "opswap_c0");
        chk("opswap_c1", char_out, 8'h34);
        @(negedge clk);

        key(0); key(13);
        get_char(8'h30, "zero_c0");
        chk("zero_done", char_valid, 0);

        key(2); key(12); key(3); key(13);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", char_valid, 0);
        chk("rst_mid_out", char_out, 8'h43);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (char_valid) seen = 1'b1;
        end
        chk("rst_mid_silent", seen, 0);
        key(9); key(13);
        get_char(8'h39, "post_rst_c0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port key_valid, input, 1, one-cycle pulse marking a keypad event.
REQ-004 SHALL have port key_code, input, 4; 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 clear, 15 no-op.
REQ-005 SHALL have port char_ready, input, 1, display sink can accept a character.
REQ-006 SHALL have port char_valid, output, 1, char_out holds a character to transfer.
REQ-007 SHALL have port char_out, output, 8, ASCII character to display.
REQ-008 SHALL have port busy, output, 1, high in states MUL, CONV and OUT.
REQ-009 SHALL have port err, output, 1, high in state ERR.

Function
REQ-010 SHALL implement states IDLE, OPA, OPB, MUL, CONV, OUT and ERR.
REQ-011 IDLE, on a digit: SHALL load operand A with the digit value and go to OPA.
REQ-012 IDLE, on an operator, '=' or no-op: SHALL ignore the key.
REQ-013 OPA/OPB, on a digit: SHALL set operand = operand*10 + digit.
REQ-014 OPA/OPB, on a fourth digit or any operand value >255: SHALL go to ERR.
REQ-015 OPA, on an operator: SHALL latch the operator, clear B and go to OPB.
REQ-016 OPA, on '=': SHALL take result = A and go to CONV.
REQ-017 OPB, on an operator: SHALL replace the latched operator, with B still zero and no digit counted.
REQ-018 OPB, on '=' with zero B digits entered: SHALL go to ERR.
REQ-019 OPB, on '=' with '+': SHALL compute 16-bit unsigned A+B in one cycle and go to CONV.
REQ-020 OPB, on '=' with '-' and A≥B: SHALL give result A−B with neg=0.
REQ-021 OPB, on '=' with '-' and A<B: SHALL give result B−A with neg=1; then go to CONV.
REQ-022 OPB, on '=' with '*': SHALL enter MUL, a shift-add multiply taking exactly 8 cycles to a 16-bit product, then go to CONV.
REQ-023 CONV SHALL convert the 16-bit result to 5 BCD digits by double-dabble in exactly 16 cycles, then go to OUT.
REQ-024 OUT SHALL emit '-' (0x2D) first when neg=1.
REQ-025 OUT SHALL then emit decimal digits (0x30+d), most significant first, with leading zeros suppressed; result 0 emits a single '0'.
REQ-026 SHALL raise char_valid and hold char_out stable until a transfer occurs; a transfer is char_valid && char_ready on a rising clk edge.
REQ-027 Next character: SHALL appear in the cycle after a transfer.
REQ-028 After the last transfer: SHALL drop char_valid and go to IDLE.
REQ-029 ERR SHALL emit 'E' (0x45) once with the same handshake, then remain in ERR with char_valid low until a clear key.
REQ-030 Clear (14), in any state and any cycle: SHALL go to IDLE, clear operands, result, neg and digit counts, and drop char_valid next cycle, aborting any MUL/CONV/OUT.
REQ-031 In MUL, CONV and OUT: SHALL ignore all keys other than clear.
REQ-032 Key events: SHALL be sampled only when key_valid=1.
REQ-033 Simultaneous key_valid and final transfer: SHALL ignore a non-clear key.
REQ-034 When char_valid=0: SHALL drive char_out to 0x43 ('C').

Reset
REQ-035 On reset: state SHALL be IDLE.
REQ-036 On reset: char_valid=0, char_out=0x43, busy=0 and err=0.
REQ-037 On reset: operands, result, neg and digit counters SHALL be 0.
REQ-038 On reset, including mid-MUL/CONV/OUT: SHALL abort immediately with no further characters.

Verification
REQ-039 Keys 1,2,+,7,= with char_ready=1 -> busy high; chars 0x31,0x39 on consecutive transfers; then IDLE, char_out=0x43.
REQ-040 Keys 3,-,5,= -> chars 0x2D,0x32; neg path exercised.
REQ-041 Keys 2,5,5,*,2,5,5,= -> 8 MUL cycles, 16 CONV cycles, then chars "65025" (0x36,0x35,0x30,0x32,0x35).
REQ-042 Keys 2,5,6 -> err=1 and single char 0x45; following digit ignored; clear -> IDLE, err=0.
REQ-043 Result "19" with char_ready held low 10 cycles -> char_out stays 0x31 with char_valid=1 throughout; no character lost or duplicated.
REQ-044 Clear mid-OUT after the first char -> char_valid=0 next cycle; reset asserted mid-MUL -> immediate IDLE with outputs at reset values.
